// File: rtl/nebula_pkg.sv
// Shared NIU/NoC definitions: TX source indices and TX scheduler state.
package nebula_pkg;

  localparam int SRC_WR  = 0;
  localparam int SRC_RD  = 1;
  localparam int SRC_RSP = 2;

  typedef enum logic [0:0] {
    TXS_IDLE,
    TXS_LOCKED
  } txs_e;

endpackage

// File: rtl/nebula_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module nebula_rr_arb #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Upper segment [ptr..N-1] first, then wrap to the lowest index.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && IW'(i) >= ptr) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/nebula_niu_tx_sched.sv
// NIU transmit injection scheduler: packet-level round-robin with
// wormhole locking and credit-based flow control onto noc_tx.
module nebula_niu_tx_sched
  import nebula_pkg::*;
#(
  parameter  int NUM_SRC = 3,
  parameter  int FLIT_W  = 64,
  parameter  int CREDITS = 4,
  localparam int SRC_W   = $clog2(NUM_SRC),
  localparam int CRD_W   = $clog2(CREDITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*FLIT_W-1:0] src_flit,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      tx_valid,
  output logic [FLIT_W-1:0]         tx_flit,
  output logic                      tx_last,
  output logic [SRC_W-1:0]          tx_src,
  input  logic                      credit_ret,
  output logic [CRD_W-1:0]          credits,
  output logic                      busy,
  output logic                      err_credit_ovf
);

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);
  localparam logic [SRC_W-1:0] SRC_TOP = SRC_W'(NUM_SRC - 1);

  txs_e              state_q, state_d;
  logic [SRC_W-1:0]  owner_q, owner_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic              err_q, err_d;
  logic              tx_valid_q, tx_valid_d;
  logic [FLIT_W-1:0] tx_flit_q, tx_flit_d;
  logic              tx_last_q, tx_last_d;
  logic [SRC_W-1:0]  tx_src_q, tx_src_d;

  logic [NUM_SRC-1:0] arb_gnt;
  logic [SRC_W-1:0]   arb_idx;
  logic               arb_any;

  logic              has_crd;
  logic              accept;
  logic [SRC_W-1:0]  sel;
  logic [FLIT_W-1:0] sel_flit;
  logic              sel_last;
  logic [SRC_W-1:0]  sel_nxt;

  nebula_rr_arb #(.N(NUM_SRC)) u_arb (
    .req (src_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    has_crd   = (credits_q != '0);
    src_ready = '0;
    sel       = arb_idx;
    if (state_q == TXS_LOCKED) begin
      sel            = owner_q;
      src_ready[sel] = src_valid[sel] && has_crd;
    end else if (arb_any && has_crd) begin
      src_ready = arb_gnt;
    end
    accept = |src_ready;

    sel_flit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SRC_W'(i)) sel_flit = src_flit[i*FLIT_W +: FLIT_W];
    end
    sel_last = src_last[sel];
    sel_nxt  = (sel == SRC_TOP) ? '0 : sel + SRC_W'(1);

    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (sel_last) begin
        state_d  = TXS_IDLE;
        rr_ptr_d = sel_nxt;
      end else begin
        state_d = TXS_LOCKED;
        owner_d = sel;
      end
    end

    credits_d = credits_q;
    err_d     = err_q;
    unique case ({accept, credit_ret})
      2'b10: credits_d = credits_q - CRD_W'(1);
      2'b01: begin
        if (credits_q == CRD_MAX) err_d = 1'b1;
        else credits_d = credits_q + CRD_W'(1);
      end
      default: ;
    endcase

    tx_valid_d = accept;
    tx_flit_d  = accept ? sel_flit : tx_flit_q;
    tx_last_d  = accept ? sel_last : tx_last_q;
    tx_src_d   = accept ? sel : tx_src_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TXS_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      credits_q  <= CRD_MAX;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_flit_q  <= '0;
      tx_last_q  <= 1'b0;
      tx_src_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      credits_q  <= credits_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_flit_q  <= tx_flit_d;
      tx_last_q  <= tx_last_d;
      tx_src_q   <= tx_src_d;
    end
  end

  assign tx_valid       = tx_valid_q;
  assign tx_flit        = tx_flit_q;
  assign tx_last        = tx_last_q;
  assign tx_src         = tx_src_q;
  assign credits        = credits_q;
  assign busy           = (state_q == TXS_LOCKED);
  assign err_credit_ovf = err_q;

endmodule

// File: tb/tb_nebula_niu_tx_sched.sv
// Directed bench for nebula_niu_tx_sched with hand-computed expectations.
module tb_nebula_niu_tx_sched;

  localparam int NS = 3;
  localparam int FW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   src_valid;
  logic [NS*FW-1:0] src_flit;
  logic [NS-1:0]   src_last;
  logic [NS-1:0]   src_ready;
  logic            tx_valid;
  logic [FW-1:0]   tx_flit;
  logic            tx_last;
  logic [1:0]      tx_src;
  logic            credit_ret;
  logic [2:0]      credits;
  logic            busy;
  logic            err_credit_ovf;

  int checks = 0;
  int errors = 0;

  nebula_niu_tx_sched #(.NUM_SRC(NS), .FLIT_W(FW), .CREDITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .src_valid      (src_valid),
    .src_flit       (src_flit),
    .src_last       (src_last),
    .src_ready      (src_ready),
    .tx_valid       (tx_valid),
    .tx_flit        (tx_flit),
    .tx_last        (tx_last),
    .tx_src         (tx_src),
    .credit_ret     (credit_ret),
    .credits        (credits),
    .busy           (busy),
    .err_credit_ovf (err_credit_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v,
                         input logic [63:0] f, input logic l);
    src_valid[i]        = v;
    src_flit[i*FW +: FW] = f;
    src_last[i]         = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0;
    src_flit = '0;
    src_last = '0;
    credit_ret = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  logic [63:0] e_flit;

  initial begin
    // 1: reset state
    do_reset();
    check("rst_credits", 64'(credits), 64'd4);
    check("rst_txv", 64'(tx_valid), 64'd0);
    check("rst_ready", 64'(src_ready), 64'd0);
    check("rst_err", 64'(err_credit_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_flit", tx_flit, 64'd0);

    // 2: single source 3-flit packet
    for (int k = 0; k < 3; k++) begin
      set_src(0, 1'b1, 64'hA0 + 64'(k), k == 2);
      #1;
      check("p3_ready", 64'(src_ready), 64'b001);
      step();
      check("p3_txv", 64'(tx_valid), 64'd1);
      check("p3_flit", tx_flit, 64'hA0 + 64'(k));
      check("p3_last", 64'(tx_last), (k == 2) ? 64'd1 : 64'd0);
      check("p3_src", 64'(tx_src), 64'd0);
      check("p3_busy", 64'(busy), (k == 2) ? 64'd0 : 64'd1);
      check("p3_crd", 64'(credits), 64'(3 - k));
    end
    set_src(0, 1'b0, 64'h0, 1'b0);
    step();
    check("p3_idle_txv", 64'(tx_valid), 64'd0);
    check("p3_hold_flit", tx_flit, 64'hA2);

    // 3: fairness with single-flit packets
    do_reset();
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 64'hC0 + 64'(i), 1'b1);
    for (int k = 0; k < 6; k++) begin
      credit_ret = (k > 0);
      #1;
      check("rr_ready", 64'(src_ready), 64'(1 << (k % 3)));
      step();
      check("rr_src", 64'(tx_src), 64'(k % 3));
      check("rr_flit", tx_flit, 64'hC0 + 64'(k % 3));
      check("rr_crd", 64'(credits), 64'd3);
    end
    src_valid = '0;
    credit_ret = 1'b0;

    // 4: wormhole lock, with a gap in the owner stream
    do_reset();
    credit_ret = 1'b1;
    set_src(1, 1'b1, 64'hB0, 1'b0);
    #1;
    check("wh_c0_ready", 64'(src_ready), 64'b010);
    step();
    set_src(0, 1'b1, 64'hD0, 1'b1);
    set_src(1, 1'b1, 64'hB1, 1'b0);
    #1;
    check("wh_c1_ready", 64'(src_ready), 64'b010);
    step();
    set_src(1, 1'b0, 64'hB1, 1'b0);
    #1;
    check("wh_gap_ready", 64'(src_ready), 64'b000);
    step();
    check("wh_gap_busy", 64'(busy), 64'd1);
    check("wh_gap_txv", 64'(tx_valid), 64'd0);
    set_src(1, 1'b1, 64'hB2, 1'b0);
    #1;
    check("wh_c3_ready", 64'(src_ready), 64'b010);
    step();
    set_src(1, 1'b1, 64'hB3, 1'b1);
    #1;
    check("wh_tail_ready", 64'(src_ready), 64'b010);
    step();
    check("wh_tail_flit", tx_flit, 64'hB3);
    check("wh_tail_last", 64'(tx_last), 64'd1);
    set_src(1, 1'b0, 64'h0, 1'b0);
    #1;
    check("wh_next_ready", 64'(src_ready), 64'b001);
    step();
    check("wh_next_src", 64'(tx_src), 64'd0);
    check("wh_next_flit", tx_flit, 64'hD0);
    check("wh_crd", 64'(credits), 64'd4);
    src_valid = '0;
    credit_ret = 1'b0;

    // 5: credit stall
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_src(2, 1'b1, 64'hE0 + 64'(k), 1'b0);
      step();
      check("cs_crd", 64'(credits), 64'(3 - k));
      check("cs_flit", tx_flit, 64'hE0 + 64'(k));
    end
    set_src(2, 1'b1, 64'hE4, 1'b0);
    #1;
    check("cs_stall_ready", 64'(src_ready), 64'b000);
    step();
    check("cs_stall_txv", 64'(tx_valid), 64'd0);
    check("cs_stall_busy", 64'(busy), 64'd1);
    check("cs_stall_crd", 64'(credits), 64'd0);
    for (int k = 4; k < 6; k++) begin
      e_flit = 64'hE0 + 64'(k);
      credit_ret = 1'b1;
      #1;
      check("cs_ret_ready", 64'(src_ready), 64'b000);
      step();
      check("cs_ret_crd", 64'(credits), 64'd1);
      credit_ret = 1'b0;
      set_src(2, 1'b1, e_flit, k == 5);
      #1;
      check("cs_rel_ready", 64'(src_ready), 64'b100);
      step();
      check("cs_rel_flit", tx_flit, e_flit);
      check("cs_rel_crd", 64'(credits), 64'd0);
    end
    check("cs_end_last", 64'(tx_last), 64'd1);
    check("cs_end_busy", 64'(busy), 64'd0);
    src_valid = '0;

    // 6: overflow, then reset mid-packet
    do_reset();
    credit_ret = 1'b1;
    step();
    check("ovf_crd", 64'(credits), 64'd4);
    check("ovf_err", 64'(err_credit_ovf), 64'd1);
    credit_ret = 1'b0;
    step();
    check("ovf_sticky", 64'(err_credit_ovf), 64'd1);
    set_src(0, 1'b1, 64'hF0, 1'b0);
    step();
    check("mr_busy_pre", 64'(busy), 64'd1);
    check("mr_crd_pre", 64'(credits), 64'd3);
    rst = 1'b1;
    #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_crd", 64'(credits), 64'd4);
    check("mr_err", 64'(err_credit_ovf), 64'd0);
    check("mr_txv", 64'(tx_valid), 64'd0);
    src_valid = '0;
    step();
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
